// File: rtl/fifo32_8.sv
// rtl/fifo32_8.sv - eight-entry 32-bit synchronous FIFO with ack/err handshake flags
//
// Buffers words from a bursty producer ahead of a 32-bit register stage.
// A binary-encoded EMPTY/NORMAL/FULL state machine resolves each request.
// Every request receives a registered ack or err pulse.
//
// Ports:
//   clk         single clock; all state changes happen on the rising edge
//   reset       synchronous, active-high reset
//   wr_en, din  write request and its data word
//   rd_en       read request
//   dout        registered read data; changes only on an accepted read
//   full, empty decoded from the state register
//   wr_ack/err  write accepted/rejected on the last edge (pulses)
//   rd_ack/err  read accepted/rejected on the last edge (pulses)
//   data_count  number of stored words, 0..DEPTH
module fifo32_8 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             wr_ack,
    output logic             wr_err,
    output logic             rd_ack,
    output logic             rd_err,
    output logic [AW:0]      data_count
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_NORMAL = 2'd1,
        ST_FULL   = 2'd2
    } state_t;

    localparam logic [AW:0] COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      count_next;
    logic             wr_ok;
    logic             rd_ok;

    // Acceptance depends only on the state before the edge. In EMPTY a
    // concurrent read is rejected because the word being written is not yet
    // readable. In FULL a write is accepted only when a read frees a slot
    // in the same edge.
    always_comb begin
        wr_ok      = 1'b0;
        rd_ok      = 1'b0;
        count_next = data_count;
        state_next = state;
        case (state)
            ST_EMPTY: begin
                wr_ok = wr_en;
            end
            ST_NORMAL: begin
                wr_ok = wr_en;
                rd_ok = rd_en;
            end
            ST_FULL: begin
                rd_ok = rd_en;
                wr_ok = wr_en && rd_en;
            end
            default: ;
        endcase

        case ({wr_ok, rd_ok})
            2'b10:   count_next = data_count + COUNT_ONE;
            2'b01:   count_next = data_count - COUNT_ONE;
            default: ;
        endcase

        if (count_next == '0) begin
            state_next = ST_EMPTY;
        end else if (count_next == COUNT_FULL) begin
            state_next = ST_FULL;
        end else begin
            state_next = ST_NORMAL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp         <= '0;
            rp         <= '0;
            data_count <= '0;
            dout       <= '0;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
            rd_ack     <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            data_count <= count_next;
            wr_ack     <= wr_en && wr_ok;
            wr_err     <= wr_en && !wr_ok;
            rd_ack     <= rd_en && rd_ok;
            rd_err     <= rd_en && !rd_ok;
            if (wr_ok) begin
                wp <= wp + 1'b1;
            end
            if (rd_ok) begin
                // In FULL with both requests, wp == rp: this reads the old
                // word while the write below replaces it on the same edge.
                dout <= mem[rp];
                rp   <= rp + 1'b1;
            end
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[wp] <= din;
        end
    end

    assign full  = (state == ST_FULL);
    assign empty = (state == ST_EMPTY);

endmodule
